// File: rtl/currency_accum_multi.sv
// Multi-channel currency accumulator: synchronises acceptor channels, detects one
// event per insertion, and sums accepted values into an overflow-protected total.
module currency_accum_multi #(
  parameter int CURRENCY_WIDTH = 7,
  parameter int NUM_CH         = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                currency_valid,
  input  logic [NUM_CH*CURRENCY_WIDTH-1:0] currency_value,
  input  logic                             dispense_valid,
  input  logic                             refund_req,
  output logic [CURRENCY_WIDTH-1:0]        total_currency,
  output logic                             currency_avail,
  output logic [NUM_CH-1:0]                coin_accepted,
  output logic [NUM_CH-1:0]                coin_reject,
  output logic                             refund_valid,
  output logic [CURRENCY_WIDTH-1:0]        refund_amount
);

  localparam int W = CURRENCY_WIDTH;

  typedef enum logic [1:0] {EMPTY, HOLD, REFUND} state_e;

  state_e                                 state_q, state_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0]     vsync_q;
  logic [SYNC_STAGES-1:0][NUM_CH*W-1:0]   dsync_q;
  logic [NUM_CH-1:0]                      sv_w, sv_d_q;
  logic [NUM_CH-1:0]                      edge_w, collide_w, svc_mask_w, sel_oh_w;
  logic [NUM_CH-1:0][W-1:0]               sync_val_w;
  logic [NUM_CH-1:0][W-1:0]               val_q, val_d;
  logic [NUM_CH-1:0]                      pend_q, pend_d;
  logic [W-1:0]                           sel_val_w;
  logic [W-1:0]                           total_q, total_d;
  logic [W-1:0]                           refund_amt_q, refund_amt_d;
  logic [W:0]                             sum_w;
  logic [NUM_CH-1:0]                      acc_q, acc_d, rej_q, rej_d;
  logic                                   service_en;

  // Valid and value travel through the same number of stages so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= '0;
      dsync_q <= '0;
      sv_d_q  <= '0;
    end else begin
      vsync_q <= {vsync_q[SYNC_STAGES-2:0], currency_valid};
      dsync_q <= {dsync_q[SYNC_STAGES-2:0], currency_value};
      sv_d_q  <= sv_w;
    end
  end

  assign sv_w = vsync_q[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign sync_val_w[gi] = dsync_q[SYNC_STAGES-1][gi*W +: W];
    end
  endgenerate

  // A channel that sees a second insertion while still pending is held out of
  // service for that cycle so it never gets accept and reject together.
  always_comb begin
    edge_w     = sv_w & ~sv_d_q;
    collide_w  = edge_w & pend_q;
    svc_mask_w = pend_q & ~collide_w;
  end

  always_comb begin
    sel_oh_w  = '0;
    sel_val_w = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (svc_mask_w[i]) begin
        sel_oh_w    = '0;
        sel_oh_w[i] = 1'b1;
        sel_val_w   = val_q[i];
      end
    end
  end

  assign sum_w = {1'b0, total_q} + {1'b0, sel_val_w};

  always_comb begin
    state_d      = state_q;
    total_d      = total_q;
    refund_amt_d = refund_amt_q;
    acc_d        = '0;
    rej_d        = collide_w;
    pend_d       = pend_q;
    val_d        = val_q;
    service_en   = 1'b0;

    case (state_q)
      EMPTY: service_en = 1'b1;
      HOLD: begin
        if (dispense_valid) begin
          total_d = '0;
          state_d = EMPTY;
        end else if (refund_req) begin
          refund_amt_d = total_q;
          total_d      = '0;
          state_d      = REFUND;
        end else begin
          service_en = 1'b1;
        end
      end
      REFUND: state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (service_en && (|sel_oh_w)) begin
      pend_d = pend_q & ~sel_oh_w;
      if ((sel_val_w != '0) && !sum_w[W]) begin
        total_d = sum_w[W-1:0];
        acc_d   = sel_oh_w;
        state_d = HOLD;
      end else begin
        rej_d = rej_d | sel_oh_w;
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (edge_w[i] && !pend_q[i]) begin
        pend_d[i] = 1'b1;
        val_d[i]  = sync_val_w[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      total_q      <= '0;
      refund_amt_q <= '0;
      acc_q        <= '0;
      rej_q        <= '0;
      pend_q       <= '0;
      val_q        <= '0;
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      refund_amt_q <= refund_amt_d;
      acc_q        <= acc_d;
      rej_q        <= rej_d;
      pend_q       <= pend_d;
      val_q        <= val_d;
    end
  end

  assign total_currency = total_q;
  assign currency_avail = (state_q == HOLD);
  assign coin_accepted  = acc_q;
  assign coin_reject    = rej_q;
  assign refund_valid   = (state_q == REFUND);
  assign refund_amount  = refund_amt_q;

endmodule
